// File: rtl/chip_link_pkg.sv
// chip_link_pkg: types and sizing helpers shared by the chip-link transmitter
// (chip_link_tx) and its mirror receiver (chip_link_rx).
//   link_state_e   : link-level FSM states
//   clog2          : ceil(log2(value)), 0 for value <= 1
//   calc_cw        : connection-select bits for CONNECT connections
//   calc_nb        : beats per routed word
//   calc_padded_w  : routed word width rounded up to whole beats
//   idx_w          : counter width able to index n items (at least 1 bit)
package chip_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ERR,
        RETRY
    } link_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned connect);
        return clog2(connect);
    endfunction

    function automatic int unsigned calc_nb(input int unsigned fw,
                                            input int unsigned connect,
                                            input int unsigned beat_w);
        return (fw + calc_cw(connect) + beat_w - 1) / beat_w;
    endfunction

    function automatic int unsigned calc_padded_w(input int unsigned fw,
                                                  input int unsigned connect,
                                                  input int unsigned beat_w);
        return calc_nb(fw, connect, beat_w) * beat_w;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chip_link_beat_mux.sv
// chip_link_beat_mux: selects beat beat_idx of the padded word and produces
// its even parity bit, optionally inverted for error injection.
//   padded_word : NB*CHIPDATA_WIDTH word, beat k at [k*W +: W]
//   beat_idx    : beat to present
//   inject      : invert the parity of the presented beat
//   beat_data   : selected beat ('0 for an index beyond NB-1)
//   beat_par    : XOR of beat_data, XOR inject
module chip_link_beat_mux
    import chip_link_pkg::*;
#(
    parameter int unsigned CHIPDATA_WIDTH = 16,
    parameter int unsigned NB             = 4,
    parameter int unsigned IDX_W          = idx_w(NB)
) (
    input  logic [NB*CHIPDATA_WIDTH-1:0] padded_word,
    input  logic [IDX_W-1:0]             beat_idx,
    input  logic                         inject,
    output logic [CHIPDATA_WIDTH-1:0]    beat_data,
    output logic                         beat_par
);

    always_comb begin
        beat_data = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (beat_idx == IDX_W'(k)) begin
                beat_data = padded_word[k*CHIPDATA_WIDTH +: CHIPDATA_WIDTH];
            end
        end
        beat_par = (^beat_data) ^ inject;
    end

endmodule

// File: rtl/chip_link_tx.sv
// chip_link_tx: peer-side chip-link transmitter. Latches one routed word
// {conn_sel, flit}, sends it as NB beats LSB-first with even parity, honours
// receiver backpressure and replays the whole word when the receiver flags a
// parity error, up to MAX_RETRY times, after which the word is dropped.
//   clk, rst_n        : clock, synchronous active-low reset
//   word_in/_valid    : word offered upstream; word_in_ready = block idle
//   send_data_out     : current beat; send_data_valid / send_data_ready handshake
//   send_data_par     : XOR of send_data_out
//   send_data_err     : receiver parity-error pulse (honoured in SEND/WAIT_ERR)
//   tx_done / tx_fail : one-cycle pulses, word delivered / dropped
//   retry_cnt         : retries used on the current word
// Optional: `define CHIP_LINK_TX_ERR_INJECT_EN adds inject_par_err, which
// inverts the parity of the presented beat until that beat transfers.
module chip_link_tx
    import chip_link_pkg::*;
#(
    parameter int unsigned FW             = 59,
    parameter int unsigned CONNECT        = 2,
    parameter int unsigned CHIPDATA_WIDTH = 16,
    parameter int unsigned ERR_WIN        = 4,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [FW+clog2(CONNECT)-1:0]        word_in,
    input  logic                                word_in_valid,
    output logic                                word_in_ready,
    output logic [CHIPDATA_WIDTH-1:0]           send_data_out,
    output logic                                send_data_valid,
    output logic                                send_data_par,
    input  logic                                send_data_ready,
    input  logic                                send_data_err,
`ifdef CHIP_LINK_TX_ERR_INJECT_EN
    input  logic                                inject_par_err,
`endif
    output logic                                tx_done,
    output logic                                tx_fail,
    output logic [clog2(MAX_RETRY+1)-1:0]       retry_cnt
);

    localparam int unsigned WW  = FW + calc_cw(CONNECT);
    localparam int unsigned NB  = calc_nb(FW, CONNECT, CHIPDATA_WIDTH);
    localparam int unsigned PW  = calc_padded_w(FW, CONNECT, CHIPDATA_WIDTH);
    localparam int unsigned BIW = idx_w(NB);
    localparam int unsigned WCW = idx_w(ERR_WIN);
    localparam int unsigned RCW = clog2(MAX_RETRY + 1);

    link_state_e         state, state_n;
    logic [WW-1:0]       shadow;
    logic [PW-1:0]       padded;
    logic [BIW-1:0]      beat_idx, beat_idx_n;
    logic [WCW-1:0]      win_cnt, win_cnt_n;
    logic [RCW-1:0]      retry_n;
    logic                load_word;
    logic                xfer;
    logic                inject_eff;
    logic [CHIPDATA_WIDTH-1:0] mux_data;
    logic                mux_par;

    assign word_in_ready   = (state == IDLE);
    assign send_data_valid = (state == SEND);
    assign xfer            = send_data_valid & send_data_ready;

    always_comb begin
        padded         = '0;
        padded[WW-1:0] = shadow;
    end

`ifdef CHIP_LINK_TX_ERR_INJECT_EN
    // A stalled beat keeps its corrupted parity even after the request drops,
    // so the receiver is guaranteed to see the bad beat when it finally takes it.
    logic inj_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_hold <= 1'b0;
        end else if (state != SEND || xfer || send_data_err) begin
            inj_hold <= 1'b0;
        end else begin
            inj_hold <= inj_hold | inject_par_err;
        end
    end

    assign inject_eff = send_data_valid & (inject_par_err | inj_hold);
`else
    assign inject_eff = 1'b0;
`endif

    chip_link_beat_mux #(
        .CHIPDATA_WIDTH (CHIPDATA_WIDTH),
        .NB             (NB),
        .IDX_W          (BIW)
    ) u_beat_mux (
        .padded_word (padded),
        .beat_idx    (beat_idx),
        .inject      (inject_eff),
        .beat_data   (mux_data),
        .beat_par    (mux_par)
    );

    assign send_data_out = send_data_valid ? mux_data : '0;
    assign send_data_par = send_data_valid & mux_par;

    always_comb begin
        state_n    = state;
        beat_idx_n = beat_idx;
        win_cnt_n  = win_cnt;
        retry_n    = retry_cnt;
        load_word  = 1'b0;
        tx_done    = 1'b0;
        tx_fail    = 1'b0;

        case (state)
            IDLE: begin
                if (word_in_valid) begin
                    state_n    = SEND;
                    beat_idx_n = '0;
                    retry_n    = '0;
                    load_word  = 1'b1;
                end
            end
            SEND, WAIT_ERR: begin
                // err takes priority over both the last-beat transfer and the
                // end of the error window.
                if (send_data_err) begin
                    if (retry_cnt < RCW'(MAX_RETRY)) begin
                        retry_n = retry_cnt + RCW'(1);
                        state_n = RETRY;
                    end else begin
                        state_n = IDLE;
                        tx_fail = 1'b1;
                    end
                end else if (state == SEND) begin
                    if (xfer) begin
                        if (beat_idx == BIW'(NB - 1)) begin
                            state_n   = WAIT_ERR;
                            win_cnt_n = '0;
                        end else begin
                            beat_idx_n = beat_idx + BIW'(1);
                        end
                    end
                end else begin
                    if (win_cnt == WCW'(ERR_WIN - 1)) begin
                        state_n = IDLE;
                        tx_done = 1'b1;
                    end else begin
                        win_cnt_n = win_cnt + WCW'(1);
                    end
                end
            end
            RETRY: begin
                state_n    = SEND;
                beat_idx_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            beat_idx  <= '0;
            win_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_n;
            beat_idx  <= beat_idx_n;
            win_cnt   <= win_cnt_n;
            retry_cnt <= retry_n;
            if (load_word) begin
                shadow <= word_in;
            end
        end
    end

endmodule

// File: tb/tb_chip_link_tx.sv
module tb_chip_link_tx;

    localparam int ERR_WIN   = 4;
    localparam int MAX_RETRY = 3;
    localparam int NB        = 4;

    typedef logic [3:0][15:0] beats_t;
    typedef logic [3:0]       pars_t;

    typedef struct {
        logic [59:0] word;
        beats_t      beats;
        pars_t       pars;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [59:0] word_in = '0;
    logic        word_in_valid = 1'b0;
    logic        word_in_ready;
    logic [15:0] send_data_out;
    logic        send_data_valid;
    logic        send_data_par;
    logic        send_data_ready = 1'b0;
    logic        send_data_err = 1'b0;
`ifdef CHIP_LINK_TX_ERR_INJECT_EN
    logic        inject_par_err = 1'b0;
`endif
    logic        tx_done;
    logic        tx_fail;
    logic [1:0]  retry_cnt;

    int    checks = 0;
    int    failures = 0;
    string cur_tag = "init";

    always #5 clk = ~clk;

    chip_link_tx #(
        .FW             (59),
        .CONNECT        (2),
        .CHIPDATA_WIDTH (16),
        .ERR_WIN        (ERR_WIN),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .word_in         (word_in),
        .word_in_valid   (word_in_valid),
        .word_in_ready   (word_in_ready),
        .send_data_out   (send_data_out),
        .send_data_valid (send_data_valid),
        .send_data_par   (send_data_par),
        .send_data_ready (send_data_ready),
        .send_data_err   (send_data_err),
`ifdef CHIP_LINK_TX_ERR_INJECT_EN
        .inject_par_err  (inject_par_err),
`endif
        .tx_done         (tx_done),
        .tx_fail         (tx_fail),
        .retry_cnt       (retry_cnt)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%b required=%b t=%0t", cur_tag, nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%h required=%h t=%0t", cur_tag, nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0d required=%0d t=%0t", cur_tag, nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference framing: zero-pad to 64 bits, beat k is bits [16k +: 16],
    // parity is the XOR of the beat.
    function automatic beats_t model_beats(input logic [59:0] w);
        logic [63:0] p;
        beats_t      b;
        p = {4'b0000, w};
        for (int k = 0; k < NB; k++) b[k] = p[k*16 +: 16];
        return b;
    endfunction

    function automatic pars_t model_pars(input beats_t b);
        pars_t p;
        for (int k = 0; k < NB; k++) p[k] = ^b[k];
        return p;
    endfunction

    task automatic err_cycle_checks(input int att);
        chk1("fail_pulse", tx_fail, att == MAX_RETRY);
        chk1("no_done_on_err", tx_done, 1'b0);
        chki("retry_at_err", int'(retry_cnt), att);
    endtask

    // Sends one word. Attempts 0..n_err-1 receive an err pulse d cycles after
    // their last-beat transfer (d=0: same cycle, d=ERR_WIN: final window cycle).
    task automatic run_word(input logic [59:0] w, input beats_t eb, input pars_t ep,
                            input int n_err, input bit rnd_ready, input int fixed_d,
                            input int stall_beat, input int stall_len);
        int n_att, nb, d, guard, stall_cnt;
        bit err_now, xfer, errs_this, finished;
        n_att = (n_err < MAX_RETRY) ? n_err + 1 : MAX_RETRY + 1;
        word_in = w;
        word_in_valid = 1'b1;
        send_data_ready = 1'b0;
        send_data_err = 1'b0;
        #1;
        guard = 0;
        while (!word_in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!word_in_ready) begin
            chk1("accept_timeout", word_in_ready, 1'b1);
            word_in_valid = 1'b0;
            return;
        end
        step();
        word_in_valid = 1'b0;
        chk1("accept_to_valid", send_data_valid, 1'b1);
        finished = 1'b0;
        for (int att = 0; att < n_att && !finished; att++) begin
            errs_this = (att < n_err);
            d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, ERR_WIN));
            nb = 0;
            guard = 0;
            stall_cnt = 0;
            err_now = 1'b0;
            while (nb < NB && !err_now) begin
                if (guard > 300) begin
                    chk1("beat_timeout", 1'b0, 1'b1);
                    send_data_ready = 1'b0;
                    return;
                end
                guard++;
                if (nb == stall_beat && stall_cnt < stall_len) begin
                    send_data_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    send_data_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                xfer = send_data_valid && send_data_ready;
                err_now = errs_this && d == 0 && xfer && nb == NB - 1;
                send_data_err = err_now;
                #1;
                chk1("beat_valid", send_data_valid, 1'b1);
                chkd("beat_data", send_data_out, eb[nb]);
                chk1("beat_par", send_data_par, ep[nb]);
                if (err_now) err_cycle_checks(att);
                else chk1("done_early", tx_done, 1'b0);
                if (xfer) nb++;
                step();
                send_data_err = 1'b0;
            end
            if (!err_now) begin
                for (int off = 1; off <= ERR_WIN; off++) begin
                    send_data_ready = 1'($urandom_range(0, 1));
                    err_now = errs_this && d == off;
                    send_data_err = err_now;
                    #1;
                    chk1("win_valid", send_data_valid, 1'b0);
                    if (err_now) err_cycle_checks(att);
                    else chk1("done_timing", tx_done, off == ERR_WIN);
                    step();
                    send_data_err = 1'b0;
                    if (err_now) break;
                end
            end
            #1;
            if (errs_this) begin
                if (att < MAX_RETRY) begin
                    chk1("gap_valid", send_data_valid, 1'b0);
                    chki("retry_inc", int'(retry_cnt), att + 1);
                    step();
                    chk1("replay_valid", send_data_valid, 1'b1);
                end else begin
                    chk1("fail_ready", word_in_ready, 1'b1);
                    chki("fail_retry_cnt", int'(retry_cnt), MAX_RETRY);
                    finished = 1'b1;
                end
            end else begin
                chk1("done_ready", word_in_ready, 1'b1);
                chki("done_retry_cnt", int'(retry_cnt), att);
                finished = 1'b1;
            end
        end
        send_data_ready = 1'b0;
        send_data_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [63:0] r;
        logic [59:0] w;
        beats_t      eb;

        tbl[0].word = 60'h0123456789ABCDEF;
        tbl[0].beats = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        tbl[0].pars = 4'b0000;
        tbl[1].word = {12'hABC, 16'h1234, 16'h0007, 16'hFFFE};
        tbl[1].beats = {16'h0ABC, 16'h1234, 16'h0007, 16'hFFFE};
        tbl[1].pars = 4'b1111;
        tbl[2].word = 60'h800000000000001;
        tbl[2].beats = {16'h0800, 16'h0000, 16'h0000, 16'h0001};
        tbl[2].pars = 4'b1001;
        tbl[3].word = 60'h0;
        tbl[3].beats = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3].pars = 4'b0000;
        tbl[4].word = 60'hFFFFFFFFFFFFFFF;
        tbl[4].beats = {16'h0FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[4].pars = 4'b0000;

        cur_tag = "reset";
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk1("ready", word_in_ready, 1'b1);
        chk1("valid", send_data_valid, 1'b0);
        chkd("data", send_data_out, 16'h0000);
        chk1("par", send_data_par, 1'b0);
        chk1("done", tx_done, 1'b0);
        chk1("fail", tx_fail, 1'b0);
        chki("retry_cnt", int'(retry_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            cur_tag = $sformatf("table%0d", i);
            run_word(tbl[i].word, tbl[i].beats, tbl[i].pars, 0, 1'b0, -1, -1, 0);
            step();
        end

        cur_tag = "backpressure";
        run_word(tbl[0].word, tbl[0].beats, tbl[0].pars, 0, 1'b0, -1, 2, 5);
        step();
        cur_tag = "single_err";
        run_word(tbl[0].word, tbl[0].beats, tbl[0].pars, 1, 1'b0, 2, -1, 0);
        step();
        cur_tag = "exhaust";
        run_word(tbl[0].word, tbl[0].beats, tbl[0].pars, 4, 1'b0, 1, -1, 0);
        step();
        cur_tag = "collision";
        run_word(tbl[1].word, tbl[1].beats, tbl[1].pars, 1, 1'b0, 0, -1, 0);
        step();
        cur_tag = "last_win_err";
        run_word(tbl[2].word, tbl[2].beats, tbl[2].pars, 1, 1'b0, ERR_WIN, -1, 0);
        step();

        cur_tag = "reset_mid";
        word_in = tbl[0].word;
        word_in_valid = 1'b1;
        #1;
        chk1("ready", word_in_ready, 1'b1);
        step();
        word_in = tbl[4].word;
        send_data_ready = 1'b1;
        #1;
        chkd("beat0", send_data_out, 16'hCDEF);
        chk1("busy_ready", word_in_ready, 1'b0);
        step();
        send_data_ready = 1'b0;
        #1;
        chkd("beat1_not_new_word", send_data_out, 16'h89AB);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        word_in_valid = 1'b0;
        #1;
        chk1("valid", send_data_valid, 1'b0);
        chk1("ready", word_in_ready, 1'b1);
        chkd("data", send_data_out, 16'h0000);
        chki("retry_cnt", int'(retry_cnt), 0);
        step();

`ifdef CHIP_LINK_TX_ERR_INJECT_EN
        begin
            bit bad;
            cur_tag = "inject";
            word_in = tbl[0].word;
            word_in_valid = 1'b1;
            #1;
            step();
            word_in_valid = 1'b0;
            inject_par_err = 1'b1;
            send_data_ready = 1'b0;
            #1;
            chkd("data", send_data_out, 16'hCDEF);
            chk1("par_inverted", send_data_par, 1'b1);
            step();
            inject_par_err = 1'b0;
            send_data_ready = 1'b1;
            #1;
            chk1("par_held", send_data_par, 1'b1);
            bad = (send_data_par != ^send_data_out);
            step();
            send_data_ready = 1'b0;
            send_data_err = bad;
            #1;
            chk1("rx_saw_bad_par", bad, 1'b1);
            step();
            send_data_err = 1'b0;
            #1;
            chk1("gap_valid", send_data_valid, 1'b0);
            chki("retry_cnt", int'(retry_cnt), 1);
            step();
            for (int k = 0; k < NB; k++) begin
                send_data_ready = 1'b1;
                #1;
                chkd("replay_data", send_data_out, tbl[0].beats[k]);
                chk1("replay_par", send_data_par, tbl[0].pars[k]);
                step();
            end
            send_data_ready = 1'b0;
            for (int off = 1; off <= ERR_WIN; off++) begin
                #1;
                chk1("done", tx_done, off == ERR_WIN);
                step();
            end
        end
`endif

        for (int n = 0; n < 20; n++) begin
            cur_tag = $sformatf("random%0d", n);
            r = {$urandom(), $urandom()};
            w = r[59:0];
            eb = model_beats(w);
            run_word(w, eb, model_pars(eb), int'($urandom_range(0, 5)), 1'b1, -1, -1, 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
